// File: rtl/uart_rx_controller.sv
// uart_rx_controller
// Receive-side UART sequencer: synchronizes the raw serial line, hunts for a
// start bit on the oversampling BaudTick, samples every bit cell at its centre,
// assembles an LSB-first frame and presents the byte on a valid/ready handshake.
// Framing errors and overruns are reported.
// Compile-time option: define UART_RX_PARITY_EN for 8E1 frames with a live
// parity_err output; left undefined the frame is 8N1 and parity_err is tied 0.
module uart_rx_controller #(
    parameter int OVS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD_raw,
    input  logic       BaudTick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = $clog2(OVS);
    // START holds for OVS/2-1 ticks, so its last tick is reached at count OVS/2-2.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 2);
    // DATA/PARITY/STOP sample once every OVS ticks.
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;

    logic            sync1;
    logic            rxs;
    logic [TW-1:0]   tcnt;
    logic [2:0]      bcnt;
    logic [7:0]      shreg;

    logic            start_hit;
    logic            bit_hit;
    logic            last_bit;

    logic            tcnt_clr;
    logic            tcnt_inc;
    logic            bcnt_clr;
    logic            shift_en;
    logic            stop_chk;
`ifdef UART_RX_PARITY_EN
    logic            par_chk;
`endif

    logic            stop_good;
    logic            handshake;
    logic            load;
    logic            drop;

    assign start_hit = (tcnt == HALF_LAST);
    assign bit_hit   = (tcnt == FULL_LAST);
    assign last_bit  = (bcnt == 3'd7);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RxD_raw;
            rxs   <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: every transition happens on a BaudTick.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (BaudTick && !rxs) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (BaudTick && start_hit) begin
                    // A high line at the start-bit centre means the edge was a glitch.
                    state_nxt = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (BaudTick && bit_hit && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (BaudTick && bit_hit) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at the stop-bit centre so a following start bit is not missed.
                if (BaudTick && bit_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: counter controls and sample strobes for the current state.
    always_comb begin
        tcnt_clr = 1'b0;
        tcnt_inc = 1'b0;
        bcnt_clr = 1'b0;
        shift_en = 1'b0;
        stop_chk = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (BaudTick && !rxs) begin
                    tcnt_clr = 1'b1;
                end
            end
            S_START: begin
                if (BaudTick) begin
                    if (start_hit) begin
                        tcnt_clr = 1'b1;
                        bcnt_clr = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (BaudTick) begin
                    if (bit_hit) begin
                        tcnt_clr = 1'b1;
                        shift_en = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (BaudTick) begin
                    if (bit_hit) begin
                        tcnt_clr = 1'b1;
                        par_chk  = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (BaudTick) begin
                    if (bit_hit) begin
                        tcnt_clr = 1'b1;
                        stop_chk = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                tcnt_clr = 1'b0;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // Tick counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            bcnt  <= 3'd0;
            shreg <= 8'h00;
        end else begin
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 1'b1;
            end
            if (bcnt_clr) begin
                bcnt <= 3'd0;
            end else if (shift_en) begin
                bcnt <= bcnt + 1'b1;
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    // A good stop bit delivers the byte unless an unread byte is still held;
    // a handshake in the same cycle frees the holding register, so the load wins.
    assign stop_good = stop_chk && rxs;
    assign handshake = rx_valid && rx_ready;
    assign load      = stop_good && (!rx_valid || rx_ready);
    assign drop      = stop_good && rx_valid && !rx_ready;

    // Consumer-facing holding register, handshake and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_chk && !rxs;
            if (load) begin
                rx_data <= shreg;
            end
            if (load) begin
                rx_valid <= 1'b1;
            end else if (handshake) begin
                rx_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity check at the parity-bit centre; the byte is still delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_chk && (rxs != (^shreg));
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller
// Randomized and directed frames on the serial line; a reference model decides
// per frame whether a byte, framing error, parity error or overrun is expected,
// and a monitor pops expected bytes whenever the DUT hands one over.
module tb_uart_rx_controller;

    localparam int OVS  = 4;
    localparam int TDIV = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD_raw;
    logic       BaudTick;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         exp_ferr = 0;
    int         exp_perr = 0;
    int         seen_ferr = 0;
    int         seen_perr = 0;
    bit         exp_ovr = 1'b0;

    uart_rx_controller #(.OVS(OVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD_raw    (RxD_raw),
        .BaudTick   (BaudTick),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clk high out of every TDIV.
    initial begin
        BaudTick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(posedge clk);
            #1 BaudTick = 1'b1;
            @(posedge clk);
            #1 BaudTick = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, test still running");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consume handed-over bytes and count error pulses.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_byte", {24'd0, rx_data}, {24'd0, mon_exp});
            end
        end
        if (frame_err) seen_ferr++;
        if (parity_err) seen_perr++;
    end

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk iff BaudTick);
        #1;
    endtask

    // Reference model for one complete frame: a bad stop bit discards the
    // byte; otherwise a byte still held by the consumer causes an overrun.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad);
`ifdef UART_RX_PARITY_EN
        if (par_bad) exp_perr++;
`endif
        if (!stop_ok) exp_ferr++;
        else if (exp_q.size() != 0) exp_ovr = 1'b1;
        else exp_q.push_back(d);
    endtask

    // Drive one frame; each bit starts right after a BaudTick edge and lasts
    // OVS ticks. A bad stop bit is held low only through its centre sample.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad,
                              input bit lat);
        RxD_raw = 1'b0;
        tick_wait(OVS);
        for (int i = 0; i < 8; i++) begin
            RxD_raw = d[i];
            tick_wait(OVS);
        end
`ifdef UART_RX_PARITY_EN
        RxD_raw = (^d) ^ par_bad;
        tick_wait(OVS / 2);
        check("parity_err", {31'd0, parity_err}, {31'd0, par_bad});
        tick_wait(OVS / 2);
`endif
        RxD_raw = stop_ok;
        repeat (OVS / 2 - 1) @(posedge clk iff BaudTick);
        if (lat) begin
            #2;
            wait (BaudTick);
            #1;
            check("valid_before_stop", {31'd0, rx_valid}, 32'd0);
        end
        @(posedge clk iff BaudTick);
        #1;
        model_frame(d, stop_ok, par_bad);
        check("frame_err", {31'd0, frame_err}, {31'd0, !stop_ok});
        if (lat) begin
            check("valid_latency", {31'd0, rx_valid}, 32'd1);
            check("data_latency", {24'd0, rx_data}, {24'd0, d});
        end
        RxD_raw = 1'b1;
        tick_wait(OVS / 2);
    endtask

    initial begin
        logic [7:0] rd;
        bit         rs;
        bit         rp;
        logic [7:0] partial;

        rst      = 1'b0;
        RxD_raw  = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",   {24'd0, rx_data}, 32'd0);
        check("rst_valid",  {31'd0, rx_valid}, 32'd0);
        check("rst_ferr",   {31'd0, frame_err}, 32'd0);
        check("rst_ovr",    {31'd0, overrun}, 32'd0);
        check("rst_perr",   {31'd0, parity_err}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick_wait(2 * OVS);

        // Basic frame with output-latency check.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        tick_wait(OVS);

        // One-tick low glitch on an idle line.
        RxD_raw = 1'b0;
        tick_wait(1);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        RxD_raw = 1'b1;
        tick_wait(OVS);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);

        // Framing error followed by a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        tick_wait(OVS);

        // Overrun: consumer stalls across two frames.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_model", {31'd0, overrun}, {31'd0, exp_ovr});
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        exp_ovr  = 1'b0;
        check("hs_valid_clr", {31'd0, rx_valid}, 32'd0);
        check("hs_ovr_clr", {31'd0, overrun}, 32'd0);
        rx_ready = 1'b1;
        tick_wait(OVS);

        // Reset in the middle of data bit 4.
        partial = 8'hC3;
        RxD_raw = 1'b0;
        tick_wait(OVS);
        for (int i = 0; i < 4; i++) begin
            RxD_raw = partial[i];
            tick_wait(OVS);
        end
        RxD_raw = partial[4];
        tick_wait(OVS / 2);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3 rst = 1'b0;
        #1;
        check("arst_data",  {24'd0, rx_data}, 32'd0);
        check("arst_valid", {31'd0, rx_valid}, 32'd0);
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_ferr",  {31'd0, frame_err}, 32'd0);
        check("arst_ovr",   {31'd0, overrun}, 32'd0);
        check("arst_perr",  {31'd0, parity_err}, 32'd0);
        RxD_raw = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick_wait(OVS);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        tick_wait(OVS);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch still delivers the byte; matching parity is silent.
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        tick_wait(OVS);
`endif

        // Random frames, occasional bad stop bits, random gaps (including none).
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            rp = 1'b0;
`ifdef UART_RX_PARITY_EN
            rp = ($urandom_range(0, 3) == 0);
`endif
            send_frame(rd, rs, rp, 1'b0);
            tick_wait($urandom_range(0, 2 * OVS));
        end

        tick_wait(OVS);
        check("queue_drained", exp_q.size(), 32'd0);
        check("ferr_count", seen_ferr, exp_ferr);
        check("perr_count", seen_perr, exp_perr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
